// File: rtl/vnu_gen_pkg.sv
// Shared widths and lane-slicing helpers for the VNU F0 lookup block.
package vnu_gen_pkg;

    localparam int DEF_QUAN_SIZE       = 4;
    localparam int DEF_MULTI_FRAME_NUM = 2;

    // Frame-select width; a single table still gets one select bit.
    function automatic int calc_fw(input int frames);
        return (frames > 1) ? $clog2(frames) : 1;
    endfunction

    // One LUT index = magnitude bits of y0 plus all bits of y1.
    function automatic int calc_aw(input int quan);
        return 2 * quan - 1;
    endfunction

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

    localparam int DEF_FW = calc_fw(DEF_MULTI_FRAME_NUM);
    localparam int DEF_AW = calc_aw(DEF_QUAN_SIZE);

endpackage

// File: rtl/vnu_f0_delay_line.sv
// Enable-gated delay line; data stages load only behind a valid so outputs hold between valids.
module vnu_f0_delay_line #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] d_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0]            vld_q;
    logic [STAGES-1:0][WIDTH-1:0] dat_q;
    logic [STAGES:0]              vld_pipe;
    logic [STAGES:0][WIDTH-1:0]   dat_pipe;

    assign vld_pipe = {vld_q, vld_i};
    assign dat_pipe = {dat_q, d_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            dat_q <= '0;
        end else if (en_i) begin
            vld_q <= vld_pipe[STAGES-1:0];
            for (int s = 0; s < STAGES; s++) begin
                if (vld_pipe[s]) dat_q[s] <= dat_pipe[s];
            end
        end
    end

    assign vld_o = vld_pipe[STAGES];
    assign q_o   = dat_pipe[STAGES];

endmodule

// File: rtl/vnu_f0_gen.sv
// Multi-frame symmetric F0 LUT shared by LANE_NUM variable-node lanes, with aligned bypass pipeline.
module vnu_f0_gen
    import vnu_gen_pkg::*;
#(
    parameter int QUAN_SIZE       = 4,
    parameter int LANE_NUM        = 2,
    parameter int VN_DEGREE       = 3,
    parameter int PIPELINE_DEPTH  = 3,
    parameter int MULTI_FRAME_NUM = 2,
    localparam int FW = calc_fw(MULTI_FRAME_NUM),
    localparam int AW = calc_aw(QUAN_SIZE),
    localparam int RW = LANE_NUM * (VN_DEGREE - 1) * QUAN_SIZE
) (
    input  logic                          read_clk,
    input  logic                          rstn,
    input  logic                          pipe_en,
    input  logic                          in_valid,
    input  logic [FW-1:0]                 read_addr_offset,
    input  logic [LANE_NUM*QUAN_SIZE-1:0] ch_llr,
    input  logic [LANE_NUM*QUAN_SIZE-1:0] c2v_0,
    input  logic [RW-1:0]                 c2v_rest,
    input  logic                          lut_we,
    input  logic [FW-1:0]                 lut_wframe,
    input  logic [AW-1:0]                 lut_waddr,
    input  logic [QUAN_SIZE-1:0]          lut_wdata,
    output logic [LANE_NUM*QUAN_SIZE-1:0] t_port,
    output logic [LANE_NUM-1:0]           tran_en,
    output logic [RW-1:0]                 c2v_rest_out,
    output logic [FW-1:0]                 read_addr_offset_out,
    output logic                          out_valid,
    output logic                          wr_conflict
);

    localparam int LW = LANE_NUM * QUAN_SIZE;
    localparam int DW = FW + RW + LANE_NUM + LW;

    logic [QUAN_SIZE-1:0] lut_q [MULTI_FRAME_NUM][1 << AW];
    logic [LW-1:0]        t_d;
    logic [LANE_NUM-1:0]  tran_d;
    logic [LANE_NUM-1:0]  hit;
    logic                 wr_conflict_q, wr_conflict_d;

    // Table contents are configuration, not state: no reset, writes ignore pipe_en.
    always_ff @(posedge read_clk) begin
        if (lut_we) lut_q[lut_wframe][lut_waddr] <= lut_wdata;
    end

    for (genvar l = 0; l < LANE_NUM; l++) begin : g_lane
        logic [QUAN_SIZE-1:0] y0, y1, ent;
        logic [AW-1:0]        idx;

        assign y0 = ch_llr[lane_lsb(l, QUAN_SIZE) +: QUAN_SIZE];
        assign y1 = c2v_0[lane_lsb(l, QUAN_SIZE) +: QUAN_SIZE];
        // Negative y0 folds onto the stored half of the table via bitwise complement.
        assign tran_d[l] = y0[QUAN_SIZE-1];
        assign idx = tran_d[l] ? {~y0[QUAN_SIZE-2:0], ~y1} : {y0[QUAN_SIZE-2:0], y1};
        assign ent = lut_q[read_addr_offset][idx];
        assign t_d[lane_lsb(l, QUAN_SIZE) +: QUAN_SIZE] = ent ^ {QUAN_SIZE{tran_d[l]}};
        assign hit[l] = (idx == lut_waddr);
    end

    always_comb begin
        wr_conflict_d = wr_conflict_q;
        if (lut_we && in_valid && pipe_en && (lut_wframe == read_addr_offset) && (|hit))
            wr_conflict_d = 1'b1;
    end

    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) wr_conflict_q <= 1'b0;
        else       wr_conflict_q <= wr_conflict_d;
    end

    assign wr_conflict = wr_conflict_q;

    // First stage captures the combinational lookup, giving read-first behaviour against same-edge writes.
    vnu_f0_delay_line #(
        .WIDTH  (DW),
        .STAGES (PIPELINE_DEPTH - 1)
    ) u_dly (
        .clk_i  (read_clk),
        .rst_ni (rstn),
        .en_i   (pipe_en),
        .vld_i  (in_valid),
        .d_i    ({read_addr_offset, c2v_rest, tran_d, t_d}),
        .vld_o  (out_valid),
        .q_o    ({read_addr_offset_out, c2v_rest_out, tran_en, t_port})
    );

endmodule

// File: doc/vnu_f0_gen.md
VNU_F0_GEN -- requirements
Module: vnu_f0_gen

Interface
REQ-001 SHALL have parameter QUAN_SIZE, default 4, message/LLR width in bits.
REQ-002 SHALL have parameter LANE_NUM, default 2, number of VNU lanes sharing one LUT (1..8).
REQ-003 SHALL have parameter VN_DEGREE, default 3, check-node edges per variable node (2..6).
REQ-004 SHALL have parameter PIPELINE_DEPTH, default 3, pipeline stage count; register sets = PIPELINE_DEPTH-1 (PIPELINE_DEPTH >= 2).
REQ-005 SHALL have parameter MULTI_FRAME_NUM, default 2, number of frame tables (power of 2, >= 2).
REQ-006 SHALL have ports read_clk (input, 1), the single clock, and rstn (input, 1), asynchronous active-low reset; all logic is in the read_clk domain.
REQ-007 SHALL have input pipe_en (1), global advance enable; when low, every stage holds.
REQ-008 SHALL have input in_valid (1), lane inputs valid this cycle.
REQ-009 SHALL have input read_addr_offset (FW = log2 MULTI_FRAME_NUM), selecting the frame table.
REQ-010 SHALL have inputs ch_llr and c2v_0 (LANE_NUM*QUAN_SIZE each), LUT operands per lane.
REQ-011 SHALL have input c2v_rest (LANE_NUM*(VN_DEGREE-1)*QUAN_SIZE), bypass messages per lane.
REQ-012 SHALL have inputs lut_we (1), lut_wframe (FW), lut_waddr (2*QUAN_SIZE-1) and lut_wdata (QUAN_SIZE), the LUT write port.
REQ-013 SHALL have outputs t_port (LANE_NUM*QUAN_SIZE), tran_en (LANE_NUM), c2v_rest_out (same width as c2v_rest), read_addr_offset_out (FW), out_valid (1) and wr_conflict (1, sticky).

Function
REQ-014 LUT storage SHALL hold MULTI_FRAME_NUM tables of 2^(2*QUAN_SIZE-1) entries each, QUAN_SIZE bits wide; contents are not reset.
REQ-015 Per lane, with y0 = ch_llr and y1 = c2v_0: if y0[MSB] = 0, index = {y0[MSB-1:0], y1} and tran_en = 0; otherwise index = {~y0[MSB-1:0], ~y1} and tran_en = 1.
REQ-016 Per lane, t_port SHALL equal the table entry when tran_en = 0 and the bitwise inverse of the entry when tran_en = 1 (symmetric-LUT transpose).
REQ-017 Lookup SHALL use the table selected by read_addr_offset, sampled in the same cycle as the operands.
REQ-018 Latency SHALL be PIPELINE_DEPTH-1 enabled cycles from input to t_port, tran_en, c2v_rest_out, read_addr_offset_out and out_valid, all mutually aligned.
REQ-019 out_valid SHALL be in_valid delayed through the same enabled stages; the other outputs hold their last value when the corresponding valid is 0.
REQ-020 With pipe_en = 0, no stage register SHALL change and writes SHALL still be accepted.
REQ-021 A write SHALL take effect at the clock edge; a read of the same entry in the same cycle returns the old data (read-first).
REQ-022 wr_conflict SHALL set when lut_we = 1, in_valid = 1, pipe_en = 1, lut_wframe = read_addr_offset, and any lane index equals lut_waddr; it clears only on reset.
REQ-023 Lanes SHALL be fully independent; identical indices on several lanes are legal and return identical data.

Reset
REQ-024 On rstn = 0, asynchronously: all stage registers, t_port, tran_en, c2v_rest_out, read_addr_offset_out, out_valid and wr_conflict SHALL be 0.
REQ-025 A reset during operation SHALL discard all in-flight data; the first valid after release emerges after PIPELINE_DEPTH-1 enabled cycles.

Structure
REQ-026 Package vnu_gen_pkg SHALL hold the FW and LUT address-width localparams and the lane slice helper functions.
REQ-027 Sub-module vnu_f0_delay_line SHALL implement a parametrised-width, enable-gated, reset-to-zero delay of PIPELINE_DEPTH-1 stages, used for the c2v bypass, offset and valid paths.

Verification
REQ-028 The bench SHALL cover: write entry frame0 index 0x25 = 0x6; lane0 ch_llr = 0x2, c2v_0 = 0x5, offset 0 -> after 2 cycles t_port = 0x6, tran_en = 0.
REQ-029 The bench SHALL cover: same entry, lane1 ch_llr = 0xD, c2v_0 = 0xA (inverted index 0x25) -> t_port = 0x9, tran_en = 1.
REQ-030 The bench SHALL cover: frame1 index 0x25 = 0x3, alternating offset 0/1 each cycle -> outputs alternate 0x6/0x3, and read_addr_offset_out matches the offset delayed by 2.
REQ-031 The bench SHALL cover: pipe_en low for 3 cycles mid-stream -> outputs frozen, no valid lost or duplicated, and the sequence order is preserved.
REQ-032 The bench SHALL cover: a same-cycle write of 0xF to a looked-up entry -> old data returned, wr_conflict = 1 and held until rstn.
REQ-033 The bench SHALL cover: rstn asserted with 2 valids in flight -> all outputs 0 immediately, and no stale out_valid after release.
